dekatron_position_seq: RTL

Multi-digit, sequential successor to the combinational BCD-to-position decoder. Accepts a DIGITS-wide packed BCD target and drives a one-hot 10-position output per digit. Each digit moves toward its target one position per step, shortest direction first, the way a physical dekatron glow moves. Sits between the machine's BCD registers and the dekatron display/driver logic; a request/ready/done handshake sequences it.

---
 rtl/dekatron_position_seq_if.sv | 24 ++
 rtl/dekatron_position_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/dekatron_position_seq_if.sv
// Handshake and display bus for dekatron_position_seq.
// The master side drives the request and packed BCD targets. The slave side returns
// the handshake status, the one-hot glow positions and their BCD encoding.
interface dekatron_position_seq_if #(
    parameter int DIGITS = 3
);
    logic                   Request;
    logic [4*DIGITS-1:0]    Bcd;
    logic                   Ready;
    logic                   Done;
    logic                   Error;
    logic [10*DIGITS-1:0]   Position;
    logic [4*DIGITS-1:0]    CurrentBcd;

    modport master (
        output Request, Bcd,
        input  Ready, Done, Error, Position, CurrentBcd
    );

    modport slave (
        input  Request, Bcd,
        output Ready, Done, Error, Position, CurrentBcd
    );
endinterface

// File: rtl/dekatron_position_seq.sv
// dekatron_position_seq: multi-digit dekatron glow sequencer.
// Each digit walks its one-hot glow toward a latched BCD target, one position every
// STEP_CYCLES clocks, taking the shorter way round (a distance of 5 goes forward).
// Invalid codes (10..15) leave that digit where it is and raise Error.
// Optional feature macro: DEKATRON_DIRECT_LOAD_EN. When it is defined, accepted targets
// load straight into Position with no stepping.
module dekatron_position_seq #(
    parameter int DIGITS      = 3,
    parameter int STEP_CYCLES = 4
) (
    input  logic                    Clk,
    input  logic                    Rst,
    dekatron_position_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] RELOAD = 8'(STEP_CYCLES - 1);

    state_t     r_state;
    state_t     w_next_state;

    logic [9:0] r_pos [DIGITS];     // one-hot glow position per digit
    logic [3:0] r_tgt [DIGITS];     // latched target per digit
    logic       r_fwd [DIGITS];     // direction fixed at accept: 1 = forward
    logic [7:0] r_cnt;
    logic       r_error;

    logic [3:0] w_cur     [DIGITS];
    logic [3:0] w_req_tgt [DIGITS];
    logic       w_req_fwd [DIGITS];
    logic       w_req_err;
    logic       w_req_match;
    logic [9:0] w_step_pos [DIGITS];
    logic       w_step_match;
    logic       w_accept;

    assign w_accept = (r_state == S_IDLE) && bus.Request;

    // Encode each one-hot glow position into its BCD value.
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
            w_cur[i] = 4'd0;
            for (int k = 0; k < 10; k++) begin
                if (r_pos[i][k]) w_cur[i] = 4'(k);
            end
        end
    end

    // Decode the incoming request: effective targets, shortest direction, error flag.
    always_comb begin
        logic [3:0] v_code;
        logic [4:0] v_dist;
        w_req_err   = 1'b0;
        w_req_match = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            v_code = bus.Bcd[4*i +: 4];
            if (v_code > 4'd9) begin
                w_req_tgt[i] = w_cur[i];
                w_req_err    = 1'b1;
            end else begin
                w_req_tgt[i] = v_code;
            end
            v_dist = {1'b0, w_req_tgt[i]} + 5'd10 - {1'b0, w_cur[i]};
            if (v_dist >= 5'd10) v_dist = v_dist - 5'd10;
            w_req_fwd[i] = (v_dist <= 5'd5);
            if (w_req_tgt[i] != w_cur[i]) w_req_match = 1'b0;
        end
    end

    // Compute the next glow positions for one step and whether all digits then arrive.
    always_comb begin
        logic [3:0] v_next;
        w_step_match = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            w_step_pos[i] = r_pos[i];
            v_next        = w_cur[i];
            if (w_cur[i] != r_tgt[i]) begin
                if (r_fwd[i]) begin
                    w_step_pos[i] = {r_pos[i][8:0], r_pos[i][9]};
                    v_next        = (w_cur[i] == 4'd9) ? 4'd0 : w_cur[i] + 4'd1;
                end else begin
                    w_step_pos[i] = {r_pos[i][0], r_pos[i][9:1]};
                    v_next        = (w_cur[i] == 4'd0) ? 4'd9 : w_cur[i] - 4'd1;
                end
            end
            if (v_next != r_tgt[i]) w_step_match = 1'b0;
        end
    end

    // Sequencer state register.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (Rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Sequencer next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
`ifdef DEKATRON_DIRECT_LOAD_EN
                    w_next_state = S_DONE;
`else
                    w_next_state = w_req_match ? S_DONE : S_WAIT;
`endif
                end
            end
            S_WAIT: begin
                if (r_cnt == 8'd0 && w_step_match) w_next_state = S_DONE;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        bus.Ready = (r_state == S_IDLE);
        bus.Done  = (r_state == S_DONE);
        bus.Error = r_error;
    end

    // Pack the per-digit glow positions and their BCD encoding onto the bus.
    always_comb begin
        bus.Position   = '0;
        bus.CurrentBcd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            bus.Position[10*i +: 10] = r_pos[i];
            bus.CurrentBcd[4*i +: 4] = w_cur[i];
        end
    end

    // Datapath: latch targets on accept, then step every STEP_CYCLES clocks while waiting.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            // NOTE: these small per-digit arrays are plain flops, so they reset like any other register.
            for (int i = 0; i < DIGITS; i++) begin
                r_pos[i] <= 10'd1;
                r_tgt[i] <= 4'd0;
                r_fwd[i] <= 1'b0;
            end
            r_cnt   <= 8'd0;
            r_error <= 1'b0;
        end else if (w_accept) begin
            r_error <= w_req_err;
            for (int i = 0; i < DIGITS; i++) begin
                r_tgt[i] <= w_req_tgt[i];
                r_fwd[i] <= w_req_fwd[i];
`ifdef DEKATRON_DIRECT_LOAD_EN
                r_pos[i] <= 10'd1 << w_req_tgt[i];
`endif
            end
            r_cnt <= RELOAD;
        end else if (r_state == S_WAIT) begin
            if (r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end else begin
                for (int i = 0; i < DIGITS; i++) r_pos[i] <= w_step_pos[i];
                r_cnt <= RELOAD;
            end
        end
    end

endmodule
